// File: rtl/match_sequencer.sv
// match_sequencer
// ---------------------------------------------------------------------------
// Game-flow controller for the two-player pong design. Runs in the pclk
// domain beside top_ctl. It sequences the ball datapath (hold/reset, motion
// enable, serve direction) through the idle, serve, rally, point and
// game-over phases. It also keeps both players' scores and decides the winner.
// Every delay is counted in frames; a frame tick is a rising edge of vsync_in.
//
// Optional build macro: AUTO_SERVE_EN
//   defined   - SERVE_WAIT moves to PLAY by itself once the serve delay has
//               elapsed, and serve inputs are ignored (attract/demo mode,
//               single-board test).
//   undefined - the serving player must press serve after the delay.
//
// Parameters:
//   WIN_SCORE    score that ends the match (1..15)
//   SERVE_DELAY  frames in SERVE_WAIT before a serve is accepted (1..255)
//   POINT_FRAMES frames the ball stays frozen after a point (1..255)
//
// Ports:
//   clk          pixel clock
//   rst          synchronous, active-high reset
//   vsync_in     vsync from vga_timing; its rising edge is the frame tick
//   button       start/abort push button (level)
//   serve_left   left player serve (level)
//   serve_right  right player serve (level)
//   miss_left    1-clk pulse: ball passed the left paddle
//   miss_right   1-clk pulse: ball passed the right paddle
//   ball_rst     hold the ball at centre
//   ball_en      ball motion enable
//   serve_dir    0 = left serves (ball travels right), 1 = right serves
//   score_left   left player score
//   score_right  right player score
//   game_over    match finished
//   winner       0 = left, 1 = right; valid while game_over is high
//   state        IDLE=0, SERVE_WAIT=1, PLAY=2, POINT=3, GAME_OVER=4
// ---------------------------------------------------------------------------
module match_sequencer #(
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_DELAY  = 60,
    parameter int POINT_FRAMES = 45
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync_in,
    input  logic       button,
    input  logic       serve_left,
    input  logic       serve_right,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       ball_rst,
    output logic       ball_en,
    output logic       serve_dir,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic       game_over,
    output logic       winner,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SERVE_WAIT = 3'd1,
        S_PLAY       = 3'd2,
        S_POINT      = 3'd3,
        S_GAME_OVER  = 3'd4
    } state_t;

    localparam logic [3:0] WIN_C          = 4'(WIN_SCORE);
    localparam logic [7:0] SERVE_DELAY_C  = 8'(SERVE_DELAY);
    localparam logic [7:0] POINT_FRAMES_C = 8'(POINT_FRAMES);

    // Score increment that sticks at 15 instead of wrapping.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    state_t     state_q, state_d;
    logic [7:0] frame_cnt, frame_cnt_d;
    logic [3:0] score_left_d, score_right_d;
    logic       serve_dir_d, winner_d;
    logic       ball_rst_d, ball_en_d, game_over_d;

    // History registers reset to 1 so a level already high when reset is
    // released does not count as an edge.
    logic button_prev, serve_left_prev, serve_right_prev, vsync_prev;
    logic button_edge, serve_left_edge, serve_right_edge, frame_tick;
    logic serve_edge_sel;

    assign button_edge      = button & ~button_prev;
    assign serve_left_edge  = serve_left & ~serve_left_prev;
    assign serve_right_edge = serve_right & ~serve_right_prev;
    assign frame_tick       = vsync_in & ~vsync_prev;
    assign serve_edge_sel   = serve_dir ? serve_right_edge : serve_left_edge;

    assign state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            button_prev      <= 1'b1;
            serve_left_prev  <= 1'b1;
            serve_right_prev <= 1'b1;
            vsync_prev       <= 1'b1;
        end else begin
            button_prev      <= button;
            serve_left_prev  <= serve_left;
            serve_right_prev <= serve_right;
            vsync_prev       <= vsync_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            frame_cnt   <= 8'd0;
            score_left  <= 4'd0;
            score_right <= 4'd0;
            serve_dir   <= 1'b0;
            winner      <= 1'b0;
            ball_rst    <= 1'b1;
            ball_en     <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt   <= frame_cnt_d;
            score_left  <= score_left_d;
            score_right <= score_right_d;
            serve_dir   <= serve_dir_d;
            winner      <= winner_d;
            ball_rst    <= ball_rst_d;
            ball_en     <= ball_en_d;
            game_over   <= game_over_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        frame_cnt_d   = frame_cnt;
        score_left_d  = score_left;
        score_right_d = score_right;
        serve_dir_d   = serve_dir;
        winner_d      = winner;

        case (state_q)
            S_IDLE: begin
                if (button_edge) begin
                    score_left_d  = 4'd0;
                    score_right_d = 4'd0;
                    serve_dir_d   = 1'b0;
                    frame_cnt_d   = 8'd0;
                    state_d       = S_SERVE_WAIT;
                end
            end

            S_SERVE_WAIT: begin
                if (button_edge) begin
                    state_d = S_IDLE;
                end else begin
                    if (frame_tick && (frame_cnt != SERVE_DELAY_C))
                        frame_cnt_d = frame_cnt + 8'd1;
`ifdef AUTO_SERVE_EN
                    if (frame_cnt == SERVE_DELAY_C)
                        state_d = S_PLAY;
`else
                    // Serve edges from the non-serving player, or before
                    // the delay has elapsed, fall through unused.
                    if ((frame_cnt == SERVE_DELAY_C) && serve_edge_sel)
                        state_d = S_PLAY;
`endif
                end
            end

            S_PLAY: begin
                // Abort outranks any miss arriving in the same cycle.
                if (button_edge) begin
                    state_d = S_IDLE;
                end else if (miss_left && miss_right) begin
                    // Both paddles missed at once: replay the point.
                    frame_cnt_d = 8'd0;
                    state_d     = S_POINT;
                end else if (miss_left) begin
                    score_right_d = sat_inc4(score_right);
                    serve_dir_d   = 1'b0;
                    frame_cnt_d   = 8'd0;
                    state_d       = S_POINT;
                end else if (miss_right) begin
                    score_left_d = sat_inc4(score_left);
                    serve_dir_d  = 1'b1;
                    frame_cnt_d  = 8'd0;
                    state_d      = S_POINT;
                end
            end

            S_POINT: begin
                if (button_edge) begin
                    state_d = S_IDLE;
                end else if (frame_cnt == POINT_FRAMES_C) begin
                    // Points are single increments, so at most one score
                    // can equal WIN_SCORE here.
                    if ((score_left == WIN_C) || (score_right == WIN_C)) begin
                        winner_d = (score_right == WIN_C);
                        state_d  = S_GAME_OVER;
                    end else begin
                        frame_cnt_d = 8'd0;
                        state_d     = S_SERVE_WAIT;
                    end
                end else if (frame_tick) begin
                    frame_cnt_d = frame_cnt + 8'd1;
                end
            end

            S_GAME_OVER: begin
                if (button_edge) begin
                    score_left_d  = 4'd0;
                    score_right_d = 4'd0;
                    serve_dir_d   = 1'b0;
                    frame_cnt_d   = 8'd0;
                    state_d       = S_SERVE_WAIT;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state and registered, so they
        // move on the same clk edge as the state register.
        ball_rst_d  = (state_d == S_IDLE) || (state_d == S_SERVE_WAIT) ||
                      (state_d == S_GAME_OVER);
        ball_en_d   = (state_d == S_PLAY);
        game_over_d = (state_d == S_GAME_OVER);
    end

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer, built with WIN_SCORE=3, SERVE_DELAY=2
// and POINT_FRAMES=2. Expected values are worked out by hand for each step.
module tb_match_sequencer;

    logic       clk;
    logic       rst;
    logic       vsync_in;
    logic       button;
    logic       serve_left;
    logic       serve_right;
    logic       miss_left;
    logic       miss_right;
    logic       ball_rst;
    logic       ball_en;
    logic       serve_dir;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic       game_over;
    logic       winner;
    logic [2:0] state;

    int compared   = 0;
    int mismatched = 0;

    match_sequencer #(
        .WIN_SCORE   (3),
        .SERVE_DELAY (2),
        .POINT_FRAMES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .vsync_in   (vsync_in),
        .button     (button),
        .serve_left (serve_left),
        .serve_right(serve_right),
        .miss_left  (miss_left),
        .miss_right (miss_right),
        .ball_rst   (ball_rst),
        .ball_en    (ball_en),
        .serve_dir  (serve_dir),
        .score_left (score_left),
        .score_right(score_right),
        .game_over  (game_over),
        .winner     (winner),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One frame: vsync rises for one clk then falls for one clk.
    task automatic tick();
        vsync_in = 1'b1;
        step();
        vsync_in = 1'b0;
        step();
    endtask

    task automatic press_button();
        button = 1'b1;
        step();
        button = 1'b0;
        step();
    endtask

    // Called after both serve-delay frames have passed in SERVE_WAIT.
    task automatic serve_finish(input logic right);
`ifdef AUTO_SERVE_EN
        chk3("auto_serve_state", state, 3'd2);
        chk1("auto_serve_en", ball_en, 1'b1);
`else
        // The non-serving player's edge must not start the rally.
        serve_left  = ~right;
        serve_right = right;
        serve_left  = right;
        serve_right = ~right;
        step();
        chk3("wrong_server_ignored", state, 3'd1);
        serve_left  = 1'b0;
        serve_right = 1'b0;
        step();
        serve_left  = ~right;
        serve_right = right;
        step();
        chk3("serve_state", state, 3'd2);
        chk1("serve_ball_en", ball_en, 1'b1);
        chk1("serve_ball_rst", ball_rst, 1'b0);
        serve_left  = 1'b0;
        serve_right = 1'b0;
        step();
`endif
    endtask

    task automatic serve_seq(input logic right);
        tick();
        tick();
        serve_finish(right);
    endtask

    // POINT lasts two frames, then either SERVE_WAIT or GAME_OVER.
    task automatic point_wait();
        tick();
        chk3("point_hold_state", state, 3'd3);
        tick();
    endtask

    initial begin
        rst         = 1'b1;
        vsync_in    = 1'b0;
        button      = 1'b0;
        serve_left  = 1'b0;
        serve_right = 1'b0;
        miss_left   = 1'b0;
        miss_right  = 1'b0;
        step();
        step();
        step();

        // Reset state
        chk3("rst_state", state, 3'd0);
        chk1("rst_ball_rst", ball_rst, 1'b1);
        chk1("rst_ball_en", ball_en, 1'b0);
        chk1("rst_serve_dir", serve_dir, 1'b0);
        chk4("rst_score_left", score_left, 4'd0);
        chk4("rst_score_right", score_right, 4'd0);
        chk1("rst_game_over", game_over, 1'b0);
        chk1("rst_winner", winner, 1'b0);
        rst = 1'b0;
        step();

        // 1: start, early serve ignored, serve after the delay
        button = 1'b1;
        step();
        chk3("start_state", state, 3'd1);
        chk1("start_ball_rst", ball_rst, 1'b1);
        chk1("start_ball_en", ball_en, 1'b0);
        button = 1'b0;
        step();
        tick();
        serve_left = 1'b1;
        step();
        chk3("early_serve_ignored", state, 3'd1);
        serve_left = 1'b0;
        step();
        tick();
        serve_finish(1'b0);

        // 2: right paddle misses, right then serves
        miss_right = 1'b1;
        step();
        miss_right = 1'b0;
        chk3("miss_r_state", state, 3'd3);
        chk4("miss_r_score_left", score_left, 4'd1);
        chk1("miss_r_serve_dir", serve_dir, 1'b1);
        chk1("miss_r_ball_en", ball_en, 1'b0);
        chk1("miss_r_ball_rst", ball_rst, 1'b0);
        point_wait();
        chk3("point_to_serve", state, 3'd1);
        serve_seq(1'b1);

        // 3: left runs up to WIN_SCORE
        miss_right = 1'b1;
        step();
        miss_right = 1'b0;
        chk4("score_left_2", score_left, 4'd2);
        point_wait();
        serve_seq(1'b1);
        miss_right = 1'b1;
        step();
        miss_right = 1'b0;
        chk4("score_left_3", score_left, 4'd3);
        point_wait();
        chk3("gameover_state", state, 3'd4);
        chk1("gameover_flag", game_over, 1'b1);
        chk1("gameover_winner", winner, 1'b0);
        chk4("gameover_score_left", score_left, 4'd3);
        chk4("gameover_score_right", score_right, 4'd0);
        chk1("gameover_ball_rst", ball_rst, 1'b1);
        press_button();
        chk3("restart_state", state, 3'd1);
        chk4("restart_score_left", score_left, 4'd0);
        chk4("restart_score_right", score_right, 4'd0);
        chk1("restart_game_over", game_over, 1'b0);
        chk1("restart_serve_dir", serve_dir, 1'b0);

        // 4: simultaneous misses replay the point with serve_dir kept at 1
        serve_seq(1'b0);
        miss_right = 1'b1;
        step();
        miss_right = 1'b0;
        point_wait();
        serve_seq(1'b1);
        miss_left  = 1'b1;
        miss_right = 1'b1;
        step();
        miss_left  = 1'b0;
        miss_right = 1'b0;
        chk3("double_miss_state", state, 3'd3);
        chk4("double_miss_score_left", score_left, 4'd1);
        chk4("double_miss_score_right", score_right, 4'd0);
        chk1("double_miss_serve_dir", serve_dir, 1'b1);
        point_wait();
        chk3("replay_serve_wait", state, 3'd1);
        serve_seq(1'b1);

        // Ordinary left miss: right scores, left serves next
        miss_left = 1'b1;
        step();
        miss_left = 1'b0;
        chk4("miss_l_score_right", score_right, 4'd1);
        chk1("miss_l_serve_dir", serve_dir, 1'b0);
        point_wait();
        serve_seq(1'b0);

        // 5: abort beats a coincident miss; misses ignored in IDLE
        button    = 1'b1;
        miss_left = 1'b1;
        step();
        button    = 1'b0;
        miss_left = 1'b0;
        chk3("abort_state", state, 3'd0);
        chk4("abort_score_right", score_right, 4'd1);
        chk4("abort_score_left", score_left, 4'd1);
        chk1("abort_ball_rst", ball_rst, 1'b1);
        step();
        miss_left = 1'b1;
        step();
        miss_left = 1'b0;
        step();
        chk3("idle_miss_state", state, 3'd0);
        chk4("idle_miss_score_right", score_right, 4'd1);

        // 6: button held through reset release does not start a match
        button = 1'b1;
        rst    = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();
        chk3("held_button_no_start", state, 3'd0);
        button = 1'b0;
        step();

        // Reset in the middle of a rally
        press_button();
        serve_seq(1'b0);
        miss_right = 1'b1;
        step();
        miss_right = 1'b0;
        point_wait();
        serve_seq(1'b1);
        chk3("pre_rst_state", state, 3'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk3("midrst_state", state, 3'd0);
        chk1("midrst_ball_rst", ball_rst, 1'b1);
        chk1("midrst_ball_en", ball_en, 1'b0);
        chk1("midrst_serve_dir", serve_dir, 1'b0);
        chk4("midrst_score_left", score_left, 4'd0);
        chk4("midrst_score_right", score_right, 4'd0);
        chk1("midrst_game_over", game_over, 1'b0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/match_sequencer.md
Name: match_sequencer

Overview:
- Game-flow controller for the two-player pong design; sits beside top_ctl in the pclk domain.
- Sequences the ball datapath (hold/reset, enable, serve direction) through idle, serve, rally, point and game-over phases.
- Keeps both players' scores and decides the winner.
- Frame timing comes from vsync edges, so all delays are counted in frames.

Parameters:
WIN_SCORE, 9, score that ends the match (1..15)
SERVE_DELAY, 60, frames in SERVE_WAIT before a serve is accepted (1..255)
POINT_FRAMES, 45, frames the ball stays frozen after a point (1..255)

Ports:
clk  input  1  pixel clock (65 MHz pclk)
rst  input  1  synchronous, active-high reset
vsync_in  input  1  vsync from vga_timing; its rising edge is the frame tick
button  input  1  start/abort push button, level
serve_left  input  1  left player serve (local mouse left), level
serve_right  input  1  right player serve (remote mouse_left_one, delayed), level
miss_left  input  1  1-clk pulse from ball datapath: ball passed left paddle
miss_right  input  1  1-clk pulse: ball passed right paddle
ball_rst  output  1  hold ball at centre
ball_en  output  1  ball motion enable
serve_dir  output  1  0 = left serves (ball travels right), 1 = right serves
score_left  output  4  left player score
score_right  output  4  right player score
game_over  output  1  match finished
winner  output  1  0 = left, 1 = right; valid when game_over
state  output  3  IDLE=0, SERVE_WAIT=1, PLAY=2, POINT=3, GAME_OVER=4

Behaviour:
Interface:
- One clock (clk).
- Reset (rst) is synchronous and active-high.

Reset values:
- state IDLE, ball_rst 1, ball_en 0, serve_dir 0, scores 0, game_over 0, winner 0, frame_cnt 0.
- Edge-detect history registers for button, serve_left, serve_right and vsync_in reset to 1, so inputs already high at reset release produce no edge.

Edge detection and timing:
- Edge = input & ~prev, where prev is the input registered on clk. frame_tick = vsync_in rising edge.
- All outputs are registered and state-decoded. They change on the clk edge after the causing input is first sampled high, i.e. 1 clk latency.

States:
- IDLE: ball_rst=1, ball_en=0. Button edge: clear scores, serve_dir=0, frame_cnt=0, go to SERVE_WAIT.
- SERVE_WAIT: ball_rst=1, ball_en=0. frame_cnt increments on frame_tick and saturates at SERVE_DELAY. When frame_cnt==SERVE_DELAY and the serving player's serve edge occurs (serve_left if serve_dir=0, else serve_right), go to PLAY. Serve edges before the delay, or from the other player, are ignored.
- PLAY: ball_rst=0, ball_en=1.
  - miss_left: score_right+1, serve_dir=0, go to POINT.
  - miss_right: score_left+1, serve_dir=1, go to POINT.
  - miss_left and miss_right in the same cycle: no score change, serve_dir unchanged, go to POINT (replay).
- POINT: ball_en=0, ball_rst=0 (ball frozen where it left). frame_cnt cleared on entry and counts frame_ticks. At POINT_FRAMES: if either score == WIN_SCORE, go to GAME_OVER; else frame_cnt=0 and go to SERVE_WAIT.
- GAME_OVER: ball_rst=1, ball_en=0, game_over=1, winner latched = (score_right==WIN_SCORE). Button edge: clear scores, game_over=0, serve_dir=0, go to SERVE_WAIT.

Boundary conditions:
- Button edge in SERVE_WAIT, PLAY or POINT aborts to IDLE. Scores are held for display and cleared on the next start.
- Abort takes priority over a miss pulse in the same cycle.
- miss_* pulses are ignored outside PLAY.
- Scores saturate at 15 and never wrap.
- Only one score can reach WIN_SCORE, because points are single increments.
- rst asserted mid-rally returns everything to reset values on the next clk.

Optional Feature:
Macro: AUTO_SERVE_EN.
- Defined: SERVE_WAIT moves to PLAY automatically when frame_cnt reaches SERVE_DELAY; serve inputs are ignored. This allows attract/demo mode and single-board test without the remote player.
- Undefined: a serve edge from the serving player is required, as described above.

Test Plan:
1. Bench parameters WIN_SCORE=3, SERVE_DELAY=2, POINT_FRAMES=2. Release rst, pulse button -> state 1, ball_rst=1; serve_left pulse after 1 frame tick is ignored; serve_left after 2 ticks -> state 2, ball_en=1, ball_rst=0 one clk later.
2. In PLAY pulse miss_right -> score_left=1, serve_dir=1, state 3. After 2 ticks -> state 1. serve_left edge ignored; serve_right edge after 2 ticks -> state 2.
3. Play to left score 3 (three miss_right rallies) -> after POINT_FRAMES: state 4, game_over=1, winner=0, scores 3/0. Button -> state 1, scores 0/0, game_over=0.
4. miss_left and miss_right in the same clk during PLAY -> scores unchanged, serve_dir unchanged, state 3.
5. Button edge in PLAY coincident with miss_left -> state 0, score_right unchanged. miss_left pulse while in state 0 -> no score change.
6. Hold button high through rst release -> no start (state stays 0). rst pulsed mid-PLAY -> all outputs return to reset values on the next clk. With AUTO_SERVE_EN defined -> state 1 to 2 after 2 ticks with no serve input.
